// File: rtl/insn_dispatcher_pkg.sv
// Shared decode constants for insn_dispatcher: opcode map, FSM state encoding,
// error codes and the instruction word layout.
package insn_dispatcher_pkg;

   localparam logic [4:0] OP_NOP    = 5'd0;
   localparam logic [4:0] OP_CFG_LO = 5'd1;
   localparam logic [4:0] OP_CFG_HI = 5'd27;
   localparam logic [4:0] OP_RUN    = 5'd28;
   localparam logic [4:0] OP_LOOP   = 5'd29;
   localparam logic [4:0] OP_ENDL   = 5'd30;
   localparam logic [4:0] OP_EOC    = 5'd31;

   localparam logic [2:0] ST_DEC  = 3'd0;
   localparam logic [2:0] ST_CFG  = 3'd1;
   localparam logic [2:0] ST_RUN  = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_HALT = 3'd4;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_BAD_ENG = 2'd1;
   localparam logic [1:0] ERR_NESTED  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef struct packed {
      logic [4:0]  op;
      logic [26:0] arg;
   } insn_t;

endpackage

// File: rtl/insn_dispatcher.sv
// Instruction-stream dispatcher: issues config writes, engine starts and one loop level.
// Optional WAIT timeout is enabled by defining DISPATCH_TIMEOUT_EN.
module insn_dispatcher
   import insn_dispatcher_pkg::*;
#(
   parameter int IADDR_W     = 13,
   parameter int NUM_ENG     = 3,
   parameter int LOOP_W      = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [IADDR_W-1:0] iaddr,
   input  logic [31:0]        idata,
   output logic               cfg_we,
   output logic [4:0]         cfg_op,
   output logic [26:0]        cfg_arg,
   output logic [NUM_ENG-1:0] eng_start,
   input  logic [NUM_ENG-1:0] eng_done,
   output logic               busy,
   output logic               err,
   output logic [1:0]         err_code
);

   if (NUM_ENG < 1 || NUM_ENG > 256 || LOOP_W < 1 || LOOP_W > 27 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("insn_dispatcher: parameter out of range");
   end

   logic [2:0]         state;
   logic [LOOP_W-1:0]  loop_cnt;
   logic [IADDR_W-1:0] loop_start;
   logic [NUM_ENG-1:0] eng_sel;
   insn_t              insn;
   logic [7:0]         eng_id;
   logic               eng_id_ok;
   logic [NUM_ENG-1:0] eng_onehot;
   logic               done_hit;
   logic [LOOP_W-1:0]  loop_load;
   logic [IADDR_W-1:0] iaddr_inc;
   logic               timeout_hit;

   assign insn       = idata;
   assign eng_id     = insn.arg[7:0];
   assign eng_id_ok  = {1'b0, eng_id} < 9'(NUM_ENG);
   assign eng_onehot = NUM_ENG'(1) << eng_id;
   // eng_sel remembers which engine is outstanding so foreign done bits are masked off
   assign done_hit   = |(eng_done & eng_sel);
   assign loop_load  = (insn.arg[LOOP_W-1:0] == '0) ? LOOP_W'(1) : insn.arg[LOOP_W-1:0];
   assign iaddr_inc  = iaddr + IADDR_W'(1);
   assign busy       = (state != ST_HALT);
   assign err        = (err_code != ERR_NONE);

`ifdef DISPATCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || state != ST_WAIT) wait_cnt <= '0;
      else                            wait_cnt <= wait_cnt + TO_W'(1);
   end

   assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_DEC;
         iaddr      <= '0;
         cfg_we     <= 1'b0;
         cfg_op     <= '0;
         cfg_arg    <= '0;
         eng_start  <= '0;
         eng_sel    <= '0;
         loop_cnt   <= '0;
         loop_start <= '0;
         err_code   <= ERR_NONE;
      end else begin
         cfg_we    <= 1'b0;
         eng_start <= '0;
         case (state)
            ST_DEC: begin
               if (insn.op == OP_NOP) begin
                  iaddr <= iaddr_inc;
               end else if (insn.op >= OP_CFG_LO && insn.op <= OP_CFG_HI) begin
                  cfg_we  <= 1'b1;
                  cfg_op  <= insn.op;
                  cfg_arg <= insn.arg;
                  iaddr   <= iaddr_inc;
                  state   <= ST_CFG;
               end else if (insn.op == OP_RUN) begin
                  if (eng_id_ok) begin
                     eng_start <= eng_onehot;
                     eng_sel   <= eng_onehot;
                     iaddr     <= iaddr_inc;
                     state     <= ST_RUN;
                  end else begin
                     if (err_code == ERR_NONE) err_code <= ERR_BAD_ENG;
                     state <= ST_HALT;
                  end
               end else if (insn.op == OP_LOOP) begin
                  if (loop_cnt != '0) begin
                     if (err_code == ERR_NONE) err_code <= ERR_NESTED;
                     state <= ST_HALT;
                  end else begin
                     loop_cnt   <= loop_load;
                     loop_start <= iaddr_inc;
                     iaddr      <= iaddr_inc;
                  end
               end else if (insn.op == OP_ENDL) begin
                  if (loop_cnt > LOOP_W'(1)) begin
                     loop_cnt <= loop_cnt - LOOP_W'(1);
                     iaddr    <= loop_start;
                  end else begin
                     loop_cnt <= '0;
                     iaddr    <= iaddr_inc;
                  end
               end else if (insn.op == OP_EOC) begin
                  state <= ST_HALT;
               end
            end
            ST_CFG:  state <= ST_DEC;
            ST_RUN:  state <= done_hit ? ST_DEC : ST_WAIT;
            ST_WAIT: begin
               if (done_hit) begin
                  state <= ST_DEC;
               end else if (timeout_hit) begin
                  if (err_code == ERR_NONE) err_code <= ERR_TIMEOUT;
                  state <= ST_HALT;
               end
            end
            ST_HALT: state <= ST_HALT;
            default: state <= ST_DEC;
         endcase
      end
   end

endmodule

// File: tb/tb_insn_dispatcher.sv
// Scoreboard bench for insn_dispatcher: an instruction-level interpreter predicts the
// config-write / engine-start trace and final halt state of each program.
module tb_insn_dispatcher;
   import insn_dispatcher_pkg::*;

   localparam int IADDR_W = 13;
   localparam int NUM_ENG = 3;
   localparam int DEPTH   = 1 << IADDR_W;
   localparam int TO_CYC  = 10;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [IADDR_W-1:0] iaddr;
   logic [31:0]        idata;
   logic               cfg_we;
   logic [4:0]         cfg_op;
   logic [26:0]        cfg_arg;
   logic [NUM_ENG-1:0] eng_start;
   logic [NUM_ENG-1:0] eng_done = '0;
   logic               busy;
   logic               err;
   logic [1:0]         err_code;

   logic [31:0] mem [DEPTH];
   assign idata = mem[iaddr];

   insn_dispatcher #(
      .IADDR_W(IADDR_W), .NUM_ENG(NUM_ENG), .LOOP_W(16), .TIMEOUT_CYC(TO_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .iaddr(iaddr), .idata(idata), .cfg_we(cfg_we),
      .cfg_op(cfg_op), .cfg_arg(cfg_arg), .eng_start(eng_start), .eng_done(eng_done),
      .busy(busy), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                 is_cfg;
      logic [4:0]         op;
      logic [26:0]        arg;
      logic [NUM_ENG-1:0] start;
   } ev_t;

   ev_t exp_q[$];
   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  cfg_cnt = 0;
   int  start_cnt = 0;
   int  done_dly = 1;
   bit  rand_dly = 1'b0;
   int  dly_left = -1;
   logic [NUM_ENG-1:0] run_mask = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input int op, input int arg);
      logic [31:0] w;
      w = {op[4:0], arg[26:0]};
      return w;
   endfunction

   // Instruction-level interpreter; pushes expected output events, returns halt address/error.
   task automatic model(output int fin_pc, output int fin_err);
      int pc = 0, cnt = 0, ls = 0, steps = 0;
      logic [31:0] w;
      int op, arg;
      ev_t e;
      fin_err = 0;
      while (steps < 40000) begin
         w = mem[pc];
         op = int'(w[31:27]);
         arg = int'(w[26:0]);
         steps++;
         if (op == 0) begin
            pc = (pc + 1) % DEPTH;
         end else if (op <= 27) begin
            e.is_cfg = 1'b1; e.op = w[31:27]; e.arg = w[26:0]; e.start = '0;
            exp_q.push_back(e);
            pc = (pc + 1) % DEPTH;
         end else if (op == 28) begin
            if ((arg & 255) >= NUM_ENG) begin fin_err = 1; break; end
            e.is_cfg = 1'b0; e.op = '0; e.arg = '0; e.start = NUM_ENG'(1 << (arg & 255));
            exp_q.push_back(e);
            pc = (pc + 1) % DEPTH;
         end else if (op == 29) begin
            if (cnt != 0) begin fin_err = 2; break; end
            cnt = arg & 16'hFFFF;
            if (cnt == 0) cnt = 1;
            pc = (pc + 1) % DEPTH;
            ls = pc;
         end else if (op == 30) begin
            if (cnt > 1) begin cnt--; pc = ls; end
            else begin cnt = 0; pc = (pc + 1) % DEPTH; end
         end else begin
            break;
         end
      end
      fin_pc = pc;
   endtask

   // Monitor: every output event must match the head of the expected queue.
   always @(negedge clk) begin
      ev_t e;
      logic [35:0] actv, expv;
      if (rst_n && (cfg_we || eng_start != '0)) begin
         if (cfg_we) cfg_cnt++;
         if (eng_start != '0) start_cnt++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: cfg_we=%0b cfg_op=%0d eng_start=%b, expected no event", cfg_we, cfg_op, eng_start);
         end else begin
            e = exp_q.pop_front();
            if (e.is_cfg) expv = {1'b1, e.op, e.arg, {NUM_ENG{1'b0}}};
            else          expv = {1'b0, 5'd0, 27'd0, e.start};
            actv = {cfg_we, e.is_cfg ? cfg_op : 5'd0, e.is_cfg ? cfg_arg : 27'd0, eng_start};
            check("event", 64'(actv), 64'(expv));
         end
      end
   end

   // Engine model: done pulse for the started engine after a delay, noise on the others.
   always @(negedge clk) begin
      logic [NUM_ENG-1:0] d;
      if (!rst_n) begin
         dly_left = -1;
         run_mask = '0;
         eng_done = '0;
      end else begin
         if (eng_start != '0) begin
            run_mask = eng_start;
            dly_left = rand_dly ? int'($urandom_range(0, 5)) : done_dly;
         end
         d = NUM_ENG'($urandom) & ~run_mask & ~eng_start;
         if (dly_left == 0) begin
            d = d | run_mask;
            dly_left = -1;
         end else if (dly_left > 0) begin
            dly_left--;
         end
         eng_done = d;
      end
   end

   task automatic start_prog(output int fp, output int fe);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      exp_q.delete();
      model(fp, fe);
      rst_n = 1'b1;
   endtask

   task automatic finish_prog(input int fp, input int fe, input int bound);
      int n = 0;
      while (busy === 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("halt_reached", 64'(busy), 64'(0));
      check("final_iaddr", 64'(iaddr), 64'(fp));
      check("final_err_code", 64'(err_code), 64'(fe));
      check("final_err", 64'(err), 64'(fe != 0));
      repeat (3) @(negedge clk);
      check("halt_hold_iaddr", 64'(iaddr), 64'(fp));
      check("halt_hold_busy", 64'(busy), 64'(0));
      check("events_drained", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic emit(inout int a, input logic [31:0] w);
      mem[a] = w;
      a++;
   endtask

   task automatic gen_random(input int len);
      int a = 0;
      int r, body, id;
      while (a < len) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            emit(a, mk(0, $urandom));
         end else if (r <= 3) begin
            emit(a, mk($urandom_range(1, 27), $urandom));
         end else if (r <= 5) begin
            id = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 255) : $urandom_range(0, 2);
            emit(a, mk(28, ($urandom & 32'h07FF_FF00) | id));
         end else if (r <= 8) begin
            body = $urandom_range(1, 3);
            emit(a, mk(29, ($urandom & 32'h07FF_0000) | $urandom_range(0, 3)));
            for (int k = 0; k < body; k++) begin
               if ($urandom_range(0, 15) == 0) emit(a, mk(29, 1));
               else if ($urandom_range(0, 2) == 0) emit(a, mk(28, $urandom_range(0, 2)));
               else emit(a, mk($urandom_range(1, 27), $urandom));
            end
            emit(a, mk(30, $urandom));
         end else begin
            emit(a, mk(30, $urandom));
         end
      end
      mem[a] = mk(31, $urandom);
   endtask

   initial begin
      int fp, fe, s, h, w, nstart, busy_drop, c0, s0;
      logic [NUM_ENG-1:0] st_val;

      for (int i = 0; i < DEPTH; i++) mem[i] = mk(31, 0);

      // Reset state
      mem[0] = mk(5, 32'h1234);
      mem[1] = mk(31, 0);
      repeat (2) @(negedge clk);
      check("rst_iaddr", 64'(iaddr), 64'(0));
      check("rst_busy", 64'(busy), 64'(1));
      check("rst_err", 64'(err), 64'(0));
      check("rst_err_code", 64'(err_code), 64'(0));
      check("rst_cfg", 64'({cfg_we, cfg_op, cfg_arg}), 64'(0));
      check("rst_eng_start", 64'(eng_start), 64'(0));

      // Single config write
      start_prog(fp, fe);
      @(negedge clk);
      check("cfg_pulse", 64'({cfg_we, cfg_op, cfg_arg}), 64'({1'b1, 5'd5, 27'h1234}));
      check("cfg_iaddr", 64'(iaddr), 64'(1));
      @(negedge clk);
      check("cfg_we_drop", 64'(cfg_we), 64'(0));
      finish_prog(fp, fe, 20);

      // Engine 2 with done four cycles after start
      mem[0] = mk(28, 2);
      mem[1] = mk(1, 32'h77);
      mem[2] = mk(31, 0);
      rand_dly = 1'b0;
      done_dly = 4;
      start_prog(fp, fe);
      s = -1; w = -1; nstart = 0; busy_drop = 0; st_val = '0;
      for (int i = 0; i < 40 && w < 0; i++) begin
         @(negedge clk);
         if (eng_start != '0) begin nstart++; s = cyc; st_val = eng_start; end
         if (cfg_we) w = cyc;
         if (w < 0 && !busy) busy_drop++;
      end
      check("run_start_count", 64'(nstart), 64'(1));
      check("run_start_value", 64'(st_val), 64'(3'b100));
      check("run_next_fetch", 64'(w), 64'(s + 6));
      check("run_busy_held", 64'(busy_drop), 64'(0));
      finish_prog(fp, fe, 20);

      // Three-iteration loop around a config write
      mem[0] = mk(29, 3);
      mem[1] = mk(9, 32'hABC);
      mem[2] = mk(30, 0);
      mem[3] = mk(31, 0);
      c0 = cfg_cnt;
      start_prog(fp, fe);
      finish_prog(fp, fe, 60);
      check("loop_cfg_pulses", 64'(cfg_cnt - c0), 64'(3));

      // Out-of-range engine id
      mem[0] = mk(28, 7);
      mem[1] = mk(31, 0);
      s0 = start_cnt;
      start_prog(fp, fe);
      finish_prog(fp, fe, 20);
      check("bad_id_no_start", 64'(start_cnt - s0), 64'(0));
      check("bad_id_err_code", 64'(err_code), 64'(1));

      // Nested loop, stray ENDL, LOOP 0 acting as 1
      mem[0] = mk(30, 0);
      mem[1] = mk(29, 0);
      mem[2] = mk(3, 32'h5A);
      mem[3] = mk(30, 0);
      mem[4] = mk(29, 2);
      mem[5] = mk(29, 1);
      start_prog(fp, fe);
      finish_prog(fp, fe, 40);
      check("nested_err_code", 64'(err_code), 64'(2));

      // Engine never completes
      mem[0] = mk(28, 0);
      mem[1] = mk(31, 0);
      done_dly = 100000;
      start_prog(fp, fe);
`ifdef DISPATCH_TIMEOUT_EN
      s = -1; h = -1;
      for (int i = 0; i < 60 && h < 0; i++) begin
         @(negedge clk);
         if (eng_start != '0) s = cyc;
         if (!busy) h = cyc;
      end
      check("timeout_halt_cycle", 64'(h), 64'(s + TO_CYC + 1));
      check("timeout_err_code", 64'(err_code), 64'(3));
      check("timeout_err", 64'(err), 64'(1));
      check("timeout_busy", 64'(busy), 64'(0));
`else
      repeat (60) @(negedge clk);
      check("no_timeout_busy", 64'(busy), 64'(1));
      check("no_timeout_err_code", 64'(err_code), 64'(0));
`endif

      // Reset while waiting on an engine, then restart from address 0
      mem[0] = mk(28, 1);
      mem[1] = mk(3, 32'h5);
      mem[2] = mk(31, 0);
      done_dly = 100000;
      start_prog(fp, fe);
      for (int i = 0; i < 10 && eng_start == '0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midwait_rst_iaddr", 64'(iaddr), 64'(0));
      check("midwait_rst_eng_start", 64'(eng_start), 64'(0));
      check("midwait_rst_err", 64'(err), 64'(0));
      check("midwait_rst_busy", 64'(busy), 64'(1));
      exp_q.delete();
      done_dly = 2;
      model(fp, fe);
      rst_n = 1'b1;
      @(negedge clk);
      check("midwait_restart_dec", 64'(eng_start), 64'(3'b010));
      finish_prog(fp, fe, 30);

      // Address wrap: second pass over LOOP while the loop is live
      mem[0] = mk(29, 1);
      for (int i = 1; i < DEPTH; i++) mem[i] = mk(0, $urandom);
      start_prog(fp, fe);
      finish_prog(fp, fe, DEPTH + 100);
      check("wrap_err_code", 64'(err_code), 64'(2));

      // Randomized programs
      rand_dly = 1'b1;
      for (int t = 0; t < 40; t++) begin
         gen_random($urandom_range(4, 24));
         start_prog(fp, fe);
         finish_prog(fp, fe, 3000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
